ascii_dec_feeder: RTL and testbench

Upstream feeder for the three-digit scrolling display stage. Accepts ASCII characters one at a time over a valid/ready handshake, converts them to 4-bit display codes, and buffers three codes. It then emits them as a fixed 3-cycle burst (`oRD` plus `DEC`) that the scroller latches. It also generates the clean request (`oCLEAN`) and flags unsupported characters.

---
 rtl/ascii_dec_feeder_if.sv | 21 ++
 rtl/ascii_dec_feeder.sv | 154 +++++++++++++++
 tb/tb_ascii_dec_feeder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ascii_dec_feeder_if.sv
// Character-in / burst-out bundle between a character producer and ascii_dec_feeder.
// master = producer side (drives i_valid/i_data), slave = the feeder.
interface ascii_dec_feeder_if;
    logic       i_valid;
    logic [7:0] i_data;
    logic       o_ready;
    logic       oRD;
    logic [3:0] DEC;
    logic       oCLEAN;
    logic       o_err;

    modport master (
        output i_valid, i_data,
        input  o_ready, oRD, DEC, oCLEAN, o_err
    );

    modport slave (
        input  i_valid, i_data,
        output o_ready, oRD, DEC, oCLEAN, o_err
    );
endinterface

// File: rtl/ascii_dec_feeder.sv
// Purpose: ASCII -> 4-bit display codes, three-entry buffer, 3-cycle oRD burst, clean request, error pulse.
// Latency: oRD in the cycle after the 3rd code is accepted, DEC trails oRD by one cycle; o_err one cycle after acceptance.
// Backpressure: o_ready only in COLLECT; held characters wait. Optional idle auto-flush under `DEC_AUTOFLUSH_EN.
module ascii_dec_feeder #(
    parameter int CLEAN_HOLD    = 16,
    parameter int FLUSH_TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    ascii_dec_feeder_if.slave bus
);
    typedef enum logic [1:0] {COLLECT, SEND, TAIL, CLEAN} state_t;

    localparam int CW = (CLEAN_HOLD > 1) ? $clog2(CLEAN_HOLD) : 1;

    if (CLEAN_HOLD < 1 || FLUSH_TIMEOUT < 1) begin : g_bad_param
        $error("ascii_dec_feeder: CLEAN_HOLD and FLUSH_TIMEOUT must be positive");
    end

    state_t        state, state_nxt;
    logic [1:0]    fill, fill_nxt;
    logic [1:0]    phase, phase_nxt;
    logic [CW-1:0] clean_cnt, clean_nxt;
    logic [3:0]    d     [3];
    logic [3:0]    d_nxt [3];
    logic          err_nxt;

    logic          rd_q, clean_q, err_q;
    logic [3:0]    dec_q;

    logic accept, is_digit, is_space, is_cr, is_clean, flush;

    assign accept   = bus.i_valid && (state == COLLECT);
    assign is_digit = (bus.i_data >= 8'h30) && (bus.i_data <= 8'h39);
    assign is_space = (bus.i_data == 8'h20);
    assign is_cr    = (bus.i_data == 8'h0D);
    assign is_clean = (bus.i_data == 8'h43) || (bus.i_data == 8'h63);

`ifdef DEC_AUTOFLUSH_EN
    localparam int FW = $clog2(FLUSH_TIMEOUT + 1);
    logic [FW-1:0] idle_cnt;

    // Only a partially filled buffer sitting idle in COLLECT ages toward a flush.
    assign flush = (state == COLLECT) && (fill != 2'd0) && !accept
                   && (idle_cnt == FW'(FLUSH_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != COLLECT || fill == 2'd0 || accept || flush) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign flush = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        phase_nxt = phase;
        clean_nxt = clean_cnt;
        d_nxt     = d;
        err_nxt   = 1'b0;
        case (state)
            COLLECT: begin
                if (accept && (is_digit || is_space)) begin
                    for (int i = 0; i < 3; i++) begin
                        if (fill == 2'(i)) d_nxt[i] = is_space ? 4'hF : bus.i_data[3:0];
                    end
                    fill_nxt = fill + 2'd1;
                    if (fill == 2'd2) begin
                        state_nxt = SEND;
                        phase_nxt = 2'd0;
                    end
                end else if ((accept && is_cr) || flush) begin
                    // A terminator on an empty buffer is simply swallowed.
                    if (fill != 2'd0) begin
                        for (int i = 0; i < 3; i++) begin
                            if (2'(i) >= fill) d_nxt[i] = 4'hF;
                        end
                        state_nxt = SEND;
                        phase_nxt = 2'd0;
                    end
                end else if (accept && is_clean) begin
                    fill_nxt  = 2'd0;
                    d_nxt     = '{default: 4'hF};
                    clean_nxt = '0;
                    state_nxt = CLEAN;
                end else if (accept) begin
                    err_nxt = 1'b1;
                end
            end
            SEND: begin
                if (phase == 2'd2) state_nxt = TAIL;
                else               phase_nxt = phase + 2'd1;
            end
            TAIL: begin
                fill_nxt  = 2'd0;
                state_nxt = COLLECT;
            end
            CLEAN: begin
                if (clean_cnt == CW'(CLEAN_HOLD - 1)) state_nxt = COLLECT;
                else                                  clean_nxt = clean_cnt + 1'b1;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill      <= 2'd0;
            phase     <= 2'd0;
            clean_cnt <= '0;
            d         <= '{default: 4'hF};
            rd_q      <= 1'b0;
            clean_q   <= 1'b0;
            err_q     <= 1'b0;
            dec_q     <= 4'hF;
        end else begin
            fill      <= fill_nxt;
            phase     <= phase_nxt;
            clean_cnt <= clean_nxt;
            d         <= d_nxt;
            rd_q      <= (state_nxt == SEND);
            clean_q   <= (state_nxt == CLEAN);
            err_q     <= err_nxt;
            // DEC trails the strobe: d0 shows in S1, d1 in S2, d2 in TAIL.
            if (state == SEND) begin
                case (phase)
                    2'd0:    dec_q <= d[0];
                    2'd1:    dec_q <= d[1];
                    default: dec_q <= d[2];
                endcase
            end
        end
    end

    assign bus.o_ready = (state == COLLECT);
    assign bus.oRD     = rd_q;
    assign bus.DEC     = dec_q;
    assign bus.oCLEAN  = clean_q;
    assign bus.o_err   = err_q;
endmodule

// File: tb/tb_ascii_dec_feeder.sv
// Bench for ascii_dec_feeder: timeline model of expected outputs checked every cycle,
// plus directed scenarios with literal expectations. Build with +define+DEC_AUTOFLUSH_EN for the flush variant.
module tb_ascii_dec_feeder;
    localparam int MAXC = 4096;
    localparam int FT   = 20;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ascii_dec_feeder_if bus ();

    ascii_dec_feeder #(.CLEAN_HOLD(HOLD), .FLUSH_TIMEOUT(FT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model: per-interval expectations, interval c = time after rising edge c.
    int         cyc        = 0;
    int         ready_from = 0;
    int         n_acc      = 0;
    int         last_acc   = 0;
    bit         exp_rd    [MAXC];
    bit         exp_clean [MAXC];
    bit         exp_err   [MAXC];
    bit         dec_v     [MAXC];
    logic [3:0] dec_val   [MAXC];
    logic [3:0] q [$];
    logic [3:0] cur_dec = 4'hF;
    logic [7:0] ch;

    int checks = 0;
    int errors = 0;

    task automatic burst(input int e);
        while (q.size() < 3) q.push_back(4'hF);
        for (int k = 0; k < 3; k++) begin
            if (e + k < MAXC) exp_rd[e + k] = 1'b1;
            if (e + k + 1 < MAXC) begin
                dec_v[e + k + 1]   = 1'b1;
                dec_val[e + k + 1] = q[k];
            end
        end
        ready_from = e + 4;
        q.delete();
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            q.delete();
            ready_from = cyc;
            for (int i = cyc; i < MAXC; i++) begin
                exp_rd[i] = 1'b0; exp_clean[i] = 1'b0; exp_err[i] = 1'b0; dec_v[i] = 1'b0;
            end
            if (cyc < MAXC) begin
                dec_v[cyc]   = 1'b1;
                dec_val[cyc] = 4'hF;
            end
        end else if (bus.i_valid && (cyc - 1 >= ready_from)) begin
            n_acc    = n_acc + 1;
            last_acc = cyc;
            ch       = bus.i_data;
            if ((ch >= 8'h30 && ch <= 8'h39) || ch == 8'h20) begin
                q.push_back(ch == 8'h20 ? 4'hF : 4'(ch - 8'h30));
                if (q.size() == 3) burst(cyc);
            end else if (ch == 8'h0D) begin
                if (q.size() > 0) burst(cyc);
            end else if (ch == 8'h43 || ch == 8'h63) begin
                q.delete();
                for (int k = 0; k < HOLD; k++) if (cyc + k < MAXC) exp_clean[cyc + k] = 1'b1;
                ready_from = cyc + HOLD;
            end else begin
                if (cyc < MAXC) exp_err[cyc] = 1'b1;
            end
        end
`ifdef DEC_AUTOFLUSH_EN
        else if (q.size() > 0 && (cyc - 1 >= ready_from) && cyc == last_acc + FT + 1) begin
            burst(cyc);
        end
`endif
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Every wait in the stimulus goes through here, so each interval is compared once.
    task automatic tick();
        @(negedge clk);
        if (cyc >= MAXC - 32) begin
            $display("FAIL cycle_budget at cycle %0d: got overrun expected below %0d", cyc, MAXC - 32);
            $fatal(1, "cycle budget exhausted");
        end
        if (rst) begin
            cur_dec = 4'hF;
            chk("rst_oRD",    int'(bus.oRD),    0);
            chk("rst_oCLEAN", int'(bus.oCLEAN), 0);
            chk("rst_o_err",  int'(bus.o_err),  0);
            chk("rst_DEC",    int'(bus.DEC),    'hF);
        end else begin
            if (dec_v[cyc]) cur_dec = dec_val[cyc];
            chk("oRD",     int'(bus.oRD),     int'(exp_rd[cyc]));
            chk("oCLEAN",  int'(bus.oCLEAN),  int'(exp_clean[cyc]));
            chk("o_err",   int'(bus.o_err),   int'(exp_err[cyc]));
            chk("DEC",     int'(bus.DEC),     int'(cur_dec));
            chk("o_ready", int'(bus.o_ready), (cyc >= ready_from) ? 1 : 0);
        end
    endtask

    task automatic send(input logic [7:0] c);
        int start;
        int budget;
        start       = n_acc;
        budget      = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = c;
        while (n_acc == start && budget < 200) begin
            tick();
            budget++;
        end
        if (n_acc == start) chk("send_timeout", 0, 1);
        bus.i_valid = 1'b0;
    endtask

    task automatic watch(input int n, output int rd_c, output int cl_c, output int er_c,
                         output int nr_c, output int first, output logic [11:0] bd);
        rd_c = 0; cl_c = 0; er_c = 0; nr_c = 0; first = -1; bd = 12'h000;
        for (int k = 0; k < n; k++) begin
            if (k > 0) tick();
            if (bus.oRD) begin
                rd_c++;
                if (first < 0) first = k;
            end
            if (bus.oCLEAN)  cl_c++;
            if (bus.o_err)   er_c++;
            if (!bus.o_ready) nr_c++;
            if (first >= 0 && k >= first + 1 && k <= first + 3) bd = {bd[7:0], bus.DEC};
        end
    endtask

    initial begin
        int          rd_c, cl_c, er_c, nr_c, first;
        logic [11:0] bd;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        repeat (3) tick();
        #1 rst = 1'b0;
        tick();
        chk("reset_o_ready", int'(bus.o_ready), 1);
        chk("reset_DEC",     int'(bus.DEC),     'hF);

        // "123" back-to-back
        send("1"); send("2"); send("3");
        watch(8, rd_c, cl_c, er_c, nr_c, first, bd);
        chk("t1_rd_len",   rd_c,     3);
        chk("t1_rd_first", first,    0);
        chk("t1_dec_seq",  int'(bd), 'h123);
        chk("t1_notready", nr_c,     4);

        // "7" CR pads with blanks; lone CR does nothing
        send("7"); send(8'h0D);
        watch(8, rd_c, cl_c, er_c, nr_c, first, bd);
        chk("t2_dec_seq", int'(bd), 'h7FF);
        send(8'h0D);
        watch(8, rd_c, cl_c, er_c, nr_c, first, bd);
        chk("t2_cr_empty_rd",  rd_c, 0);
        chk("t2_cr_empty_err", er_c, 0);

        // "4" then 'C' clears, then a fresh burst
        send("4"); send("C");
        watch(24, rd_c, cl_c, er_c, nr_c, first, bd);
        chk("t3_clean_len", cl_c, 16);
        chk("t3_notready",  nr_c, 16);
        chk("t3_no_burst",  rd_c, 0);
        send("5"); send("6"); send("8");
        watch(8, rd_c, cl_c, er_c, nr_c, first, bd);
        chk("t3_dec_seq", int'(bd), 'h568);

        // unsupported byte between digits
        send("1"); send(8'h78);
        chk("t4_err_pulse", int'(bus.o_err), 1);
        tick();
        chk("t4_err_once", int'(bus.o_err), 0);
        send("2"); send("3");
        watch(8, rd_c, cl_c, er_c, nr_c, first, bd);
        chk("t4_dec_seq", int'(bd), 'h123);

        // space and lowercase clean
        send("5"); send(" "); send("6");
        watch(8, rd_c, cl_c, er_c, nr_c, first, bd);
        chk("t5_dec_seq", int'(bd), 'h5FF & 'hF00 | 'h0F6);
        send("c");
        watch(20, rd_c, cl_c, er_c, nr_c, first, bd);
        chk("t5_clean_len", cl_c, 16);

        // reset in S1 while "9" is held
        send("1"); send("2"); send("3");
        bus.i_valid = 1'b1;
        bus.i_data  = "9";
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        chk("t6_rd_dropped", int'(bus.oRD), 0);
        chk("t6_dec_blank",  int'(bus.DEC), 'hF);
        tick();
        #1 rst = 1'b0;
        send("9"); send("8"); send("7");
        watch(8, rd_c, cl_c, er_c, nr_c, first, bd);
        chk("t6_dec_seq", int'(bd), 'h987);

        // idle partial buffer
        send("2");
        watch(40, rd_c, cl_c, er_c, nr_c, first, bd);
`ifdef DEC_AUTOFLUSH_EN
        chk("t7_flush_delay", first,    21);
        chk("t7_dec_seq",     int'(bd), 'h2FF);
`else
        chk("t7_no_flush", rd_c, 0);
        send(8'h0D);
        watch(8, rd_c, cl_c, er_c, nr_c, first, bd);
        chk("t7_cr_dec_seq", int'(bd), 'h2FF);
`endif
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
